// File: rtl/bram_loader.sv
// Write-side loader for the instruction/data block RAM: takes a little-endian word count and
// then that many 32-bit words from a UART byte stream, and issues one RAM write strobe per word.
module bram_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 262144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_di,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] word_cnt,
  output logic [31:0] checksum
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    DONE,
    ERR
  } state_t;

  // The low address bits are forced to zero so every write is word aligned.
  localparam logic [31:0] BASE    = {BASE_ADDR[31:2], 2'b00};
  localparam logic [31:0] MAX_CNT = MAX_WORDS;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] shreg;
  logic [31:0] len;
  logic [31:0] group_word;

  // The 4th byte is taken straight from rx_data so the word is usable on the edge that samples it.
  assign group_word = {rx_data, shreg};

  // NOTE: all state is updated with non-blocking assignments in one clocked block; the
  // strobe-retire logic and the byte-assembly case below both read the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      byte_idx <= 2'd0;
      shreg    <= 24'd0;
      len      <= 32'd0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= BASE;
      mem_di   <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      word_cnt <= 32'd0;
      checksum <= 32'd0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;

      // Retire the strobe in flight; assembly of the next word continues independently.
      if (mem_en) begin
        mem_addr <= mem_addr + 32'd4;
        word_cnt <= word_cnt + 32'd1;
        checksum <= checksum + mem_di;
        if (word_cnt + 32'd1 == len) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end

      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN;
            byte_idx <= 2'd0;
            word_cnt <= 32'd0;
            checksum <= 32'd0;
            mem_addr <= BASE;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end

        LEN: begin
          if (rx_valid) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              len <= group_word;
              if (group_word == 32'd0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (group_word > MAX_CNT) begin
                state <= ERR;
                busy  <= 1'b0;
                err   <= 1'b1;
              end else begin
                state <= DATA;
              end
            end else begin
              shreg[{byte_idx, 3'b000} +: 8] <= rx_data;
            end
          end
        end

        DATA: begin
          if (rx_valid) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_di <= group_word;
              mem_en <= 1'b1;
              mem_we <= 1'b1;
            end else begin
              shreg[{byte_idx, 3'b000} +: 8] <= rx_data;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: header/data loads, zero and oversize counts, reset
// mid-load, ignored bytes and start pulses, and checksum wrap.
module tb_bram_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] word_cnt;
  logic [31:0] checksum;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] s_addr[$];
  logic [31:0] s_di[$];
  logic        prev_en = 1'b0;

  bram_loader #(
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(262144)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .mem_en  (mem_en),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_di  (mem_di),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .word_cnt(word_cnt),
    .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe recorder and always-on invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (mem_en === 1'b1) begin
        s_addr.push_back(mem_addr);
        s_di.push_back(mem_di);
      end
      if (mem_en !== mem_we) begin
        tests_failed++;
        $display("FAIL en_we_equal: mem_en=%b mem_we=%b", mem_en, mem_we);
      end
      if (mem_en === 1'b1 && prev_en === 1'b1) begin
        tests_failed++;
        $display("FAIL strobe_width: mem_en high two cycles in a row at addr %h", mem_addr);
      end
      if (done === 1'b1 && err === 1'b1) begin
        tests_failed++;
        $display("FAIL done_err_excl: done=1 err=1");
      end
      if (busy === 1'b1 && (done === 1'b1 || err === 1'b1)) begin
        tests_failed++;
        $display("FAIL busy_excl: busy=%b done=%b err=%b", busy, done, err);
      end
    end
    prev_en = mem_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    s_addr.delete();
    s_di.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tests_run++;
    if ({mem_en, mem_we, busy, done, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: en/we/busy/done/err=%b expected 00000", {mem_en, mem_we, busy, done, err});
    end
    tests_run++;
    if (mem_addr !== 32'h0 || mem_di !== 32'h0 || word_cnt !== 32'h0 || checksum !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: addr=%h di=%h cnt=%h sum=%h expected all 0", mem_addr, mem_di, word_cnt, checksum);
    end
    // Bytes in IDLE must be dropped.
    clear_log();
    send_word(32'h1234_5678);
    tick();
    tests_run++;
    if (s_addr.size() !== 0 || busy !== 1'b0 || word_cnt !== 32'h0) begin
      tests_failed++;
      $display("FAIL idle_ignore: strobes=%0d busy=%b cnt=%h expected 0/0/0", s_addr.size(), busy, word_cnt);
    end
  endtask

  task automatic test_single_word();
    clear_log();
    pulse_start();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_busy: busy=%b expected 1", busy);
    end
    send_word(32'h0000_0001);
    send_word(32'hDEAD_BEEF);
    tests_run++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h0 || mem_di !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL single_strobe: en=%b addr=%h di=%h expected 1/00000000/deadbeef", mem_en, mem_addr, mem_di);
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || word_cnt !== 32'd1 || checksum !== 32'hDEAD_BEEF || s_addr.size() !== 1) begin
      tests_failed++;
      $display("FAIL single_done: done=%b busy=%b cnt=%0d sum=%h strobes=%0d expected 1/0/1/deadbeef/1",
               done, busy, word_cnt, checksum, s_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[3] = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    clear_log();
    pulse_start();
    send_word(32'h0000_0003);
    for (int w = 0; w < 3; w++) send_word(words[w]);
    tests_run++;
    if (mem_en !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_last_strobe: en=%b done=%b expected 1/0", mem_en, done);
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || mem_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_done: done=%b en=%b expected 1/0", done, mem_en);
    end
    tests_run++;
    if (s_addr.size() !== 3) begin
      tests_failed++;
      $display("FAIL b2b_count: strobes=%0d expected 3", s_addr.size());
    end else begin
      for (int w = 0; w < 3; w++) begin
        tests_run++;
        if (s_addr[w] !== 32'(4 * w) || s_di[w] !== words[w]) begin
          tests_failed++;
          $display("FAIL b2b_word%0d: addr=%h di=%h expected %h/%h", w, s_addr[w], s_di[w], 32'(4 * w), words[w]);
        end
      end
    end
    tests_run++;
    if (word_cnt !== 32'd3 || checksum !== 32'h0033_6698 || mem_addr !== 32'd12) begin
      tests_failed++;
      $display("FAIL b2b_totals: cnt=%0d sum=%h addr=%h expected 3/00336698/0000000c", word_cnt, checksum, mem_addr);
    end
    // Bytes in DONE are dropped and the totals hold.
    send_word(32'hCAFE_F00D);
    tick();
    tests_run++;
    if (s_addr.size() !== 3 || word_cnt !== 32'd3 || mem_addr !== 32'd12 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_ignore: strobes=%0d cnt=%0d addr=%h done=%b expected 3/3/0000000c/1",
               s_addr.size(), word_cnt, mem_addr, done);
    end
  endtask

  task automatic test_zero_count();
    clear_log();
    pulse_start();
    send_word(32'h0000_0000);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || word_cnt !== 32'd0 || checksum !== 32'd0 || mem_addr !== 32'd0) begin
      tests_failed++;
      $display("FAIL zero_count: done=%b busy=%b cnt=%0d sum=%h addr=%h expected 1/0/0/0/0",
               done, busy, word_cnt, checksum, mem_addr);
    end
    tick();
    tests_run++;
    if (s_addr.size() !== 0) begin
      tests_failed++;
      $display("FAIL zero_strobes: strobes=%0d expected 0", s_addr.size());
    end
  endtask

  task automatic test_max_words();
    clear_log();
    pulse_start();
    send_word(32'h0004_0001);
    tests_run++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL over_max: err=%b done=%b busy=%b expected 1/0/0", err, done, busy);
    end
    send_word(32'h0102_0304);
    tests_run++;
    if (s_addr.size() !== 0 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_hold: strobes=%0d err=%b expected 0/1", s_addr.size(), err);
    end
    pulse_start();
    send_word(32'h0000_0001);
    send_word(32'h0000_0005);
    tick();
    tests_run++;
    if (done !== 1'b1 || err !== 1'b0 || word_cnt !== 32'd1 || checksum !== 32'd5 || s_addr.size() !== 1) begin
      tests_failed++;
      $display("FAIL after_err: done=%b err=%b cnt=%0d sum=%h strobes=%0d expected 1/0/1/5/1",
               done, err, word_cnt, checksum, s_addr.size());
    end
    // Exactly MAX_WORDS is accepted; the load is then abandoned with a reset.
    pulse_start();
    send_word(32'h0004_0000);
    tests_run++;
    if (busy !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL at_max: busy=%b err=%b done=%b expected 1/0/0", busy, err, done);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    pulse_start();
    send_word(32'h0000_0004);
    send_word(32'hAAAA_0001);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_data  = 8'h33;
    rx_valid = 1'b1;
    rst      = 1'b0;
    tick();
    rst      = 1'b1;
    rx_valid = 1'b0;
    tests_run++;
    if ({mem_en, busy, done, err} !== 4'b0 || mem_addr !== 32'h0 || mem_di !== 32'h0 ||
        word_cnt !== 32'h0 || checksum !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset: en/busy/done/err=%b addr=%h di=%h cnt=%h sum=%h expected all 0",
               {mem_en, busy, done, err}, mem_addr, mem_di, word_cnt, checksum);
    end
    send_byte(8'h44);
    tick();
    tests_run++;
    if (s_addr.size() !== 1 || mem_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_no_strobe: strobes=%0d en=%b expected 1/0", s_addr.size(), mem_en);
    end
    clear_log();
    pulse_start();
    send_word(32'h0000_0001);
    send_word(32'hA5A5_A5A5);
    tick();
    tests_run++;
    if (s_addr.size() !== 1 || s_addr[0] !== 32'h0 || s_di[0] !== 32'hA5A5_A5A5 ||
        done !== 1'b1 || word_cnt !== 32'd1) begin
      tests_failed++;
      $display("FAIL fresh_load: strobes=%0d done=%b cnt=%0d expected 1 strobe a5a5a5a5 at 0, done=1 cnt=1",
               s_addr.size(), done, word_cnt);
    end
  endtask

  task automatic test_start_ignored_and_wrap();
    clear_log();
    pulse_start();
    send_word(32'h0000_0002);
    send_word(32'hFFFF_FFFF);
    pulse_start();
    pulse_start();
    tests_run++;
    if (busy !== 1'b1 || word_cnt !== 32'd1 || mem_addr !== 32'd4 || checksum !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL start_in_data: busy=%b cnt=%0d addr=%h sum=%h expected 1/1/00000004/ffffffff",
               busy, word_cnt, mem_addr, checksum);
    end
    send_word(32'h0000_0002);
    tick();
    tests_run++;
    if (done !== 1'b1 || word_cnt !== 32'd2 || checksum !== 32'h0000_0001 || mem_addr !== 32'd8 || s_addr.size() !== 2) begin
      tests_failed++;
      $display("FAIL wrap_sum: done=%b cnt=%0d sum=%h addr=%h strobes=%0d expected 1/2/00000001/00000008/2",
               done, word_cnt, checksum, mem_addr, s_addr.size());
    end
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_zero_count();
    test_max_words();
    test_reset_mid_load();
    test_start_ignored_and_wrap();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
